fifo_block_reader: RTL and testbench
====================================

Name: fifo_block_reader

Overview:
- Consumer-side agent for the 32-bit internal test FIFO (32-entry, read/empty interface, registered data_out).
- On a start command, it pops exactly block_words words from the FIFO. Each word is presented on a valid/ready output port.
- It pulses done when the block is complete.
- It sits between the test FIFO and the ADMA data sink during internal tests.

Parameters:
- CNT_W, 10, width of the block word count and the words_sent counter. Maximum block is 2^CNT_W - 1 words.

Ports:
- CLK  in  1  single clock; all state changes on posedge CLK.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a block. Sampled only in IDLE.
- block_words  in  CNT_W  number of words to transfer. Sampled with start.
- abort  in  1  terminates the current block.
- fifo_data  in  32  FIFO data_out. Valid the cycle after a fifo_read pulse.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  out  1  FIFO read strobe.
- out_data  out  32  word presented to the sink.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data when out_valid && out_ready.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the block completes.
- words_sent  out  CNT_W  words accepted by the sink in the current or last block.

Behaviour:
- Reset: all of the following clear on the first posedge CLK with RESET=1, regardless of state. No done pulse is issued on reset.
  - state=IDLE, fifo_read=0, out_data=0, out_valid=0, busy=0, done=0, words_sent=0, remaining=0.
- States: IDLE, FETCH, WAIT, PRESENT, DONE.
- IDLE:
  - start=1, block_words!=0: latch remaining=block_words, clear words_sent, go to FETCH.
  - start=1, block_words==0: done=1 for the next cycle, stay in IDLE, words_sent cleared.
- FETCH:
  - fifo_read = (state==FETCH) && !fifo_empty. Combinational; never asserted while fifo_empty=1.
  - If !fifo_empty, go to WAIT. Otherwise stay in FETCH indefinitely (no timeout).
- WAIT:
  - Latch out_data <= fifo_data, set out_valid=1, go to PRESENT.
- PRESENT:
  - out_valid=1 and out_data held stable until accepted.
  - On out_ready=1: words_sent++, remaining--, out_valid=0.
    - If remaining was 1, go to DONE; otherwise go to FETCH.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE.
- Latency:
  - Read pulse in cycle N; out_valid from cycle N+2.
  - With out_ready held high, one word per 3 cycles when the FIFO is non-empty.
- start while busy is ignored. block_words is don't-care outside IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; out_valid=0, fifo_read=0, no done pulse; words_sent retains its value.
  - A word already popped (abort in WAIT or PRESENT) is discarded, not returned to the FIFO.
- abort and out_ready in the same PRESENT cycle: abort wins; the word is not counted.
- abort in IDLE has no effect; start and abort together in IDLE: abort wins, start ignored.
- Width rules:
  - words_sent and remaining are CNT_W bits, unsigned.
  - remaining cannot underflow, because FETCH is only entered with remaining >= 1.

Test Plan:
- Reset mid-block: reset asserted while in PRESENT -> next cycle IDLE, out_valid=0, busy=0, words_sent=0, no done.
- FIFO preloaded with 0x11111111..0x44444444, start with block_words=4, out_ready=1 -> 4 words out in order.
  - First out_valid exactly 2 cycles after the first fifo_read.
  - done pulse 1 cycle after the 4th acceptance; words_sent=4; FIFO empty.
- Empty FIFO, start with block_words=2 -> stays in FETCH with fifo_read=0.
  - Push 0xA5A5A5A5 after 10 cycles -> read fires the following cycle; word presented.
  - After the second push and acceptance, done pulses.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_data stable, no further fifo_read; counts advance only on acceptance.
- Abort: abort in WAIT during a block of 8 after 3 words accepted -> IDLE next cycle, words_sent=3, no done, one word lost from the FIFO.
- Edge cases:
  - start with block_words=0 -> done pulses next cycle, busy stays 0.
  - start pulsed while busy -> ignored, block length unchanged.

Source files
------------

// File: rtl/fifo_block_reader.sv
// fifo_block_reader
//   Consumer-side agent for the 32-bit internal test FIFO. A start command
//   pops exactly block_words words. Each word is handed to a valid/ready
//   sink. done pulses once the block completes. The block sits between the
//   test FIFO and the ADMA data sink during internal tests.
//
// Ports
//   CLK, RESET           clock; synchronous active-high reset
//   start, block_words   start command and block length (sampled in IDLE)
//   abort                drop the current block and return to IDLE
//   fifo_data/empty/read FIFO read side (data valid the cycle after read)
//   out_data/valid/ready word presented to the sink
//   busy, done           activity flag and block-complete pulse
//   words_sent           words accepted in the current or last block
module fifo_block_reader #(
    parameter int CNT_W = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [CNT_W-1:0] block_words,
    input  logic             abort,
    input  logic [31:0]      fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_read,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             zero_done;   // done pulse for a zero-length block, issued from IDLE
    logic             accept;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        if (state != S_IDLE && abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start && !abort && block_words != '0) state_nxt = S_FETCH;
                S_FETCH:   if (!fifo_empty) state_nxt = S_WAIT;
                S_WAIT:    state_nxt = S_PRESENT;
                S_PRESENT: begin
                    if (out_ready) begin
                        state_nxt = (remaining == CNT_W'(1)) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        fifo_read = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        busy      = (state != S_IDLE);
        done      = zero_done;
        case (state)
            S_FETCH:   fifo_read = !fifo_empty && !abort;
            S_PRESENT: begin
                out_valid = 1'b1;
                accept    = out_ready && !abort;
            end
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: captured word, counters, zero-length done flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_data   <= '0;
            words_sent <= '0;
            remaining  <= '0;
            zero_done  <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        words_sent <= '0;
                        remaining  <= block_words;
                        zero_done  <= (block_words == '0);
                    end
                end
                S_WAIT: begin
                    if (!abort) out_data <= fifo_data;
                end
                S_PRESENT: begin
                    if (accept) begin
                        words_sent <= words_sent + CNT_W'(1);
                        remaining  <= remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_block_reader.sv
// Testbench for fifo_block_reader: directed cycle table followed by a
// randomized run checked against a transaction-level model.
module tb_fifo_block_reader;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic [9:0]  block_words;
    logic        abort;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_read;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [9:0]  words_sent;

    fifo_block_reader #(.CNT_W(10)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .block_words(block_words),
        .abort      (abort),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        st;
        logic [9:0]  bw;
        logic        ab;
        logic        rdy;
        logic        psh;
        logic [31:0] pd;
        logic        e_read;
        logic        e_valid;
        logic        e_busy;
        logic        e_done;
        logic [9:0]  e_ws;
        logic        cd;
        logic [31:0] e_data;
        int          fcnt;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] q[$];      // FIFO contents
    logic [31:0] pend[$];   // words popped from the FIFO, not yet accepted
    logic        read_pend;
    int          n_checks;
    int          n_fail;

    function automatic void add(input logic rst, st, input logic [9:0] bw,
                                input logic ab, rdy, psh, input logic [31:0] pd,
                                input logic er, ev, eb, ed, input logic [9:0] ews,
                                input logic cd, input logic [31:0] edat, input int fc);
        vec_t v;
        v.rst = rst; v.st = st; v.bw = bw; v.ab = ab; v.rdy = rdy; v.psh = psh; v.pd = pd;
        v.e_read = er; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_ws = ews;
        v.cd = cd; v.e_data = edat; v.fcnt = fc;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: FIFO model update and input drive at negedge, outputs settle by #1.
    // A push becomes visible on fifo_empty one cycle later, like a registered FIFO.
    task automatic apply(input logic rst, st, input logic [9:0] bw,
                         input logic ab, rdy, psh, input logic [31:0] pd);
        @(negedge CLK);
        if (read_pend && q.size() > 0) begin
            fifo_data = q.pop_front();
            pend.push_back(fifo_data);
        end
        fifo_empty = (q.size() == 0);
        if (psh) q.push_back(pd);
        RESET = rst; start = st; block_words = bw; abort = ab; out_ready = rdy;
        #1;
        read_pend = fifo_read;
    endtask

    initial begin
        vec_t        v;
        int          m_busy, m_done, m_acc, m_bw;
        logic        lat1, lat2, stall, acc;
        logic [31:0] held;
        logic        st, ab, rdy, psh;
        logic [9:0]  bw;
        logic [31:0] pd;

        n_checks = 0; n_fail = 0; read_pend = 1'b0;
        RESET = 1'b1; start = 1'b0; block_words = '0; abort = 1'b0;
        out_ready = 1'b0; fifo_data = '0; fifo_empty = 1'b1;

        // Reset state
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("rst fifo_read", fifo_read, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst words_sent", words_sent, 0);

        // A: preload 4 words, block of 4 with sink always ready
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,1,1, 32'h11111111 * 32'(i+1), 0,0,0,0,0, 0,0,-1);
        add(0,1,4,0,1,0,0, 0,0,0,0,0, 0,0,-1);
        for (int k = 0; k < 4; k++) begin
            add(0,0,0,0,1,0,0, 1,0,1,0,10'(k), 0,0,-1);
            add(0,0,0,0,1,0,0, 0,0,1,0,10'(k), 0,0,-1);
            add(0,0,0,0,1,0,0, 0,1,1,0,10'(k), 1, 32'h11111111 * 32'(k+1), -1);
        end
        add(0,0,0,0,1,0,0, 0,0,1,1,4, 0,0,0);
        add(0,0,0,0,1,0,0, 0,0,0,0,4, 0,0,-1);
        // B: empty FIFO block of 2, late pushes, backpressure, start while busy
        add(0,1,2,0,1,0,0, 0,0,0,0,4, 0,0,-1);
        for (int i = 0; i < 10; i++)
            add(0,0,0,0,1,0,0, 0,0,1,0,0, 0,0,-1);
        add(0,0,0,0,1,1,32'hA5A5A5A5, 0,0,1,0,0, 0,0,-1);
        add(0,0,0,0,1,0,0, 1,0,1,0,0, 0,0,-1);
        add(0,0,0,0,0,0,0, 0,0,1,0,0, 0,0,-1);
        add(0,0,0,0,0,0,0, 0,1,1,0,0, 1,32'hA5A5A5A5,-1);
        add(0,0,0,0,0,0,0, 0,1,1,0,0, 1,32'hA5A5A5A5,-1);
        add(0,1,7,0,0,0,0, 0,1,1,0,0, 1,32'hA5A5A5A5,-1);
        add(0,0,0,0,0,1,32'h5A5A5A5A, 0,1,1,0,0, 1,32'hA5A5A5A5,-1);
        add(0,0,0,0,0,0,0, 0,1,1,0,0, 1,32'hA5A5A5A5,-1);
        add(0,0,0,0,1,0,0, 0,1,1,0,0, 1,32'hA5A5A5A5,-1);
        add(0,0,0,0,1,0,0, 1,0,1,0,1, 0,0,-1);
        add(0,0,0,0,1,0,0, 0,0,1,0,1, 0,0,-1);
        add(0,0,0,0,1,0,0, 0,1,1,0,1, 1,32'h5A5A5A5A,-1);
        add(0,0,0,0,1,0,0, 0,0,1,1,2, 0,0,0);
        add(0,0,0,0,1,0,0, 0,0,0,0,2, 0,0,-1);
        // C: zero-length block
        add(0,1,0,0,1,0,0, 0,0,0,0,2, 0,0,-1);
        add(0,0,0,0,1,0,0, 0,0,0,1,0, 0,0,-1);
        // D: abort in WAIT after 3 of 8 words accepted
        for (int i = 0; i < 5; i++)
            add(0,0,0,0,1,1, 32'h100 + 32'(i), 0,0,0,0,0, 0,0,-1);
        add(0,1,8,0,1,0,0, 0,0,0,0,0, 0,0,-1);
        for (int k = 0; k < 3; k++) begin
            add(0,0,0,0,1,0,0, 1,0,1,0,10'(k), 0,0,-1);
            add(0,0,0,0,1,0,0, 0,0,1,0,10'(k), 0,0,-1);
            add(0,0,0,0,1,0,0, 0,1,1,0,10'(k), 1, 32'h100 + 32'(k), -1);
        end
        add(0,0,0,0,1,0,0, 1,0,1,0,3, 0,0,-1);
        add(0,0,0,1,1,0,0, 0,0,1,0,3, 0,0,-1);
        add(0,0,0,0,1,0,0, 0,0,0,0,3, 0,0,-1);
        add(0,0,0,0,1,0,0, 0,0,0,0,3, 0,0,1);
        // E: reset while presenting a word
        add(0,1,3,0,0,0,0, 0,0,0,0,3, 0,0,-1);
        add(0,0,0,0,0,0,0, 1,0,1,0,0, 0,0,-1);
        add(0,0,0,0,0,0,0, 0,0,1,0,0, 0,0,-1);
        add(1,0,0,0,0,0,0, 0,1,1,0,0, 1,32'h104,-1);
        add(0,0,0,0,0,0,0, 0,0,0,0,0, 1,32'h0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,-1);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            apply(v.rst, v.st, v.bw, v.ab, v.rdy, v.psh, v.pd);
            check($sformatf("row%0d fifo_read", i), fifo_read, v.e_read);
            check($sformatf("row%0d out_valid", i), out_valid, v.e_valid);
            check($sformatf("row%0d busy", i), busy, v.e_busy);
            check($sformatf("row%0d done", i), done, v.e_done);
            check($sformatf("row%0d words_sent", i), words_sent, v.e_ws);
            if (v.cd) check($sformatf("row%0d out_data", i), out_data, v.e_data);
            if (v.fcnt >= 0) check($sformatf("row%0d fifo_level", i), 32'(q.size()), 32'(v.fcnt));
        end

        // Randomized run against a transaction-level model
        pend.delete();
        m_busy = 0; m_done = 0; m_acc = 0; m_bw = 0;
        lat1 = 0; lat2 = 0; stall = 0; held = '0;
        for (int c = 0; c < 2500; c++) begin
            st  = ($urandom_range(0, 7) == 0);
            bw  = 10'($urandom_range(0, 6));
            ab  = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            psh = (q.size() < 30) && ($urandom_range(0, 1) == 1);
            pd  = $urandom;
            apply(0, st, bw, ab, rdy, psh, pd);

            check("rnd busy", busy, 32'(m_busy));
            check("rnd done", done, 32'(m_done));
            check("rnd words_sent", 32'(words_sent), 32'(m_acc));
            if (fifo_read) check("rnd read_when_empty", fifo_empty, 0);
            if (lat2) check("rnd read_to_valid", out_valid, 1);
            if (stall) begin
                check("rnd stall_valid", out_valid, 1);
                check("rnd stall_data", out_data, held);
            end
            acc = out_valid && out_ready && !abort;
            if (acc) begin
                check("rnd popped_word_present", 32'(pend.size() > 0), 1);
                if (pend.size() > 0) check("rnd word_order", out_data, pend.pop_front());
            end

            lat2  = lat1 && !ab;
            lat1  = fifo_read;
            stall = out_valid && !out_ready && !ab;
            held  = out_data;
            if (m_busy != 0 && (ab || m_done != 0)) begin
                m_busy = 0; m_done = 0;
                if (ab) pend.delete();
            end else if (m_busy == 0) begin
                m_done = 0;
                if (st && !ab) begin
                    m_acc = 0;
                    if (bw == 0) m_done = 1;
                    else begin m_busy = 1; m_bw = int'(bw); end
                end
            end else begin
                m_done = 0;
                if (acc) begin
                    m_acc++;
                    if (m_acc == m_bw) m_done = 1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
